// File: rtl/hex_scan_driver.sv
// Time-multiplexed scan controller for an N-digit common-anode 7-segment display.
// Feeds one nibble per slot to the hex decoder and swaps in new values only at frame boundaries.

module hex_scan_digit (
  input  logic [3:0] nib,
  input  logic       active,
  input  logic       dark,
  input  logic       upper_zero_in,
  output logic       upper_zero_out,
  output logic       sel_n
);
  // Zero status ripples down from the most significant digit.
  assign upper_zero_out = (nib == 4'h0) & upper_zero_in;
  assign sel_n          = ~(active & ~dark);
endmodule

module hex_scan_driver #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    lz_blank_en,
  output logic [3:0]              nibble_out,
  output logic [NUM_DIGITS-1:0]   digit_sel_n,
  output logic                    blank,
  output logic                    frame_tick
);
  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NUM_DIGITS);

  logic [PW-1:0]                 presc;
  logic [IW-1:0]                 idx;
  logic [NUM_DIGITS-1:0][3:0]    disp;
  logic [NUM_DIGITS-1:0][3:0]    shadow;
  logic                          pending;
  logic                          slot_end;
  logic                          dark;
  logic [NUM_DIGITS:0]           uz;

  assign slot_end   = (presc == PW'(SCAN_DIV - 1));
  assign frame_tick = slot_end & (idx == IW'(NUM_DIGITS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc   <= '0;
      idx     <= '0;
      disp    <= '0;
      shadow  <= '0;
      pending <= 1'b0;
    end else begin
      presc <= slot_end ? '0 : presc + PW'(1);
      if (slot_end)
        idx <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + IW'(1);
      if (load)
        shadow <= value;
      // A load landing on the wrap edge bypasses the shadow so it shows immediately.
      if (frame_tick) begin
        if (load)
          disp <= value;
        else if (pending)
          disp <= shadow;
        pending <= 1'b0;
      end else if (load) begin
        pending <= 1'b1;
      end
    end
  end

  assign nibble_out     = disp[idx];
  assign uz[NUM_DIGITS] = 1'b1;
  assign blank          = lz_blank_en & (idx != '0) & uz[idx];
  // presc==0 is the anti-ghosting dead cycle between digits.
  assign dark           = (presc == '0) | blank;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
    hex_scan_digit u_dig (
      .nib            (disp[i]),
      .active         (idx == IW'(i)),
      .dark           (dark),
      .upper_zero_in  (uz[i+1]),
      .upper_zero_out (uz[i]),
      .sel_n          (digit_sel_n[i])
    );
  end
endmodule

// File: doc/hex_scan_driver.md
Name: hex_scan_driver

Overview:
- Time-multiplexed scan controller for an N-digit common-anode 7-segment display.
- Sits directly upstream of the team's 4-bit hex-to-segment decoder. Each slot it presents one digit's nibble on nibble_out, which feeds the decoder's din. It also drives the digit-select lines and a blank flag that gates the decoder's segment outputs.
- Holds a tear-free display value: new data is captured at any time but becomes visible only at a frame boundary.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (2..8).
- SCAN_DIV, 50000, clock cycles per digit slot (must be >= 2).

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- load  input  1  single-cycle strobe; captures value into the shadow register.
- value  input  4*NUM_DIGITS  hex value to display; digit 0 = bits [3:0] (least significant).
- lz_blank_en  input  1  enables leading-zero blanking.
- nibble_out  output  4  nibble of the currently scanned digit, to the decoder's din.
- digit_sel_n  output  NUM_DIGITS  active-low digit enables; at most one bit is low.
- blank  output  1  high when the current digit must be dark.
- frame_tick  output  1  one-cycle pulse on the last cycle of each full scan frame.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - presc=0, idx=0, disp=0, shadow=0, pending=0.
  - Outputs while in reset: nibble_out=0, digit_sel_n=all ones, blank=0, frame_tick=0.
- Prescaler:
  - presc counts 0..SCAN_DIV-1 and wraps to 0.
  - On the edge where presc==SCAN_DIV-1, idx advances by 1; NUM_DIGITS-1 wraps to 0.
- frame_tick:
  - Combinational: 1 exactly when presc==SCAN_DIV-1 and idx==NUM_DIGITS-1.
  - One cycle wide; exactly one pulse per NUM_DIGITS*SCAN_DIV cycles.
- Load and frame update:
  - load=1: shadow<=value, pending<=1.
  - At a frame wrap (frame_tick=1 edge) with pending=1: disp<=shadow, pending<=0.
  - If load and frame wrap coincide: disp<=value directly, shadow<=value, pending<=0.
  - A load that is not at a frame wrap never alters disp. Multiple loads within a frame: the last one wins.
- Output decode (combinational from registered state):
  - nibble_out = disp[4*idx +: 4].
  - Dead cycle: when presc==0, digit_sel_n is all ones (anti-ghosting).
  - Otherwise digit_sel_n has bit idx=0 and all other bits 1, unless blank=1, in which case digit_sel_n is all ones.
- Leading-zero blanking:
  - blank=1 iff lz_blank_en=1, idx!=0, and disp nibbles idx..NUM_DIGITS-1 are all zero.
  - Digit 0 is never blanked, so a value of 0 shows a single "0".
  - lz_blank_en takes effect on the same cycle it changes; it is not frame-synchronised.
- Mid-operation reset: all state returns to reset values immediately. Scanning restarts at digit 0, slot cycle 0, after rst_n deasserts.
- No arithmetic overflow paths: presc is ceil(log2(SCAN_DIV)) bits wide and idx is ceil(log2(NUM_DIGITS)) bits wide; both wrap explicitly, never by natural overflow.

Test Plan (NUM_DIGITS=4, SCAN_DIV=4):
- Reset release, no load -> digit_sel_n cycles 1111, 1110, 1110, 1110, 1111, 1101, ... nibble_out=0 throughout; frame_tick pulses every 16 cycles, on the cycle idx=3, presc=3.
- load value=16'h1A2F mid-frame -> disp unchanged until the frame_tick edge. The next frame shows nibble_out F, 2, A, 1 on idx 0..3, with blank=0.
- load 16'h0000 then 16'h00B3 in the same frame -> the next frame shows 3, B, 0, 0. Value 0000 is never displayed.
- lz_blank_en=1, disp=16'h0050 -> idx 0 and 1 are lit (0, 5); idx 2 and 3 have blank=1 and digit_sel_n=1111. With disp=0, only idx 0 is lit.
- load asserted on the frame_tick cycle with value=16'h7777 -> disp=7777 from the very next cycle; pending=0, so no further update at the following frame.
- rst_n pulled low at idx=2, presc=2 -> outputs return to reset values asynchronously, before the next clock edge. After release, scanning resumes from idx 0 with disp=0.
